uart_tx_engine: RTL and testbench

Serial transmit engine that pairs with the UART receive engine on the same bit clock and format controls. It accepts one byte at a time from the host through a single-entry holding register with a ready/load handshake. It serialises each byte as a fixed 11-bit frame (start, 7 or 8 data bits LSB first, optional parity, stop bits) onto `o_tx`, whose line format is the one the receive engine decodes.

---
 rtl/uart_tx_engine_if.sv | 23 ++
 rtl/uart_tx_engine.sv | 113 +++++++++++
 tb/tb_uart_tx_engine.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_engine_if.sv
// Host-side handshake and format controls for the UART transmit engine.
// The engine connects through the slave modport, the host through master.
interface uart_tx_engine_if;
    logic        i_load;
    logic [7:0]  i_tx_din;
    logic        i_eight;
    logic        i_pen;
    logic        i_ohel;
    logic [18:0] i_rate;
    logic        o_tx;
    logic        o_txrdy;
    logic        o_busy;

    modport master (
        output i_load, i_tx_din, i_eight, i_pen, i_ohel, i_rate,
        input  o_tx, o_txrdy, o_busy
    );

    modport slave (
        input  i_load, i_tx_din, i_eight, i_pen, i_ohel, i_rate,
        output o_tx, o_txrdy, o_busy
    );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: a single-entry holding register feeds an 11-bit frame shifter.
// Format and bit period are latched at each transfer and stay fixed for the whole frame.
module uart_tx_engine (
    input  logic              i_clk,
    input  logic              i_rst_n,
    uart_tx_engine_if.slave   bus
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e      state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic        full_q, full_d;
    logic [10:0] shift_q, shift_d;
    logic [18:0] baud_q, baud_d;
    logic [18:0] term_q, term_d;
    logic [3:0]  bit_q, bit_d;

    logic [10:0] frame;
    logic [7:0]  data_used;
    logic        parity;
    logic        load_acc;
    logic        start;

    // Frame image built from the held byte and the live format inputs at transfer time.
    always_comb begin
        data_used = bus.i_eight ? hold_q : {1'b0, hold_q[6:0]};
        parity    = (^data_used) ^ bus.i_ohel;
        frame     = '1;
        frame[0]  = 1'b0;
        if (bus.i_eight) begin
            frame[8:1] = hold_q;
            if (bus.i_pen) frame[9] = parity;
        end else begin
            frame[7:1] = hold_q[6:0];
            if (bus.i_pen) frame[8] = parity;
        end
    end

    assign load_acc = bus.i_load & ~full_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        full_d  = full_q;
        shift_d = shift_q;
        baud_d  = baud_q;
        term_d  = term_q;
        bit_d   = bit_q;
        start   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (full_q) start = 1'b1;
            end
            StShift: begin
                if (baud_q == term_q) begin
                    baud_d = '0;
                    if (bit_q == 4'd10) begin
                        if (full_q) start = 1'b1;
                        else        state_d = StIdle;
                    end else begin
                        shift_d = {1'b1, shift_q[10:1]};
                        bit_d   = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + 19'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (start) begin
            state_d = StShift;
            shift_d = frame;
            baud_d  = '0;
            bit_d   = '0;
            term_d  = (bus.i_rate == 19'd0) ? 19'd0 : bus.i_rate - 19'd1;
            full_d  = 1'b0;
        end

        // A load can never coincide with a transfer: transfer needs full, load needs empty.
        if (load_acc) begin
            hold_d = bus.i_tx_din;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            hold_q  <= '0;
            full_q  <= 1'b0;
            shift_q <= '1;
            baud_q  <= '0;
            term_q  <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            shift_q <= shift_d;
            baud_q  <= baud_d;
            term_q  <= term_d;
            bit_q   <= bit_d;
        end
    end

    assign bus.o_tx    = (state_q == StShift) ? shift_q[0] : 1'b1;
    assign bus.o_busy  = (state_q == StShift);
    assign bus.o_txrdy = ~full_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: expected frames are queued at load time and
// checked bit-by-bit, every clock, by a line monitor.
module tb_uart_tx_engine;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_engine_if bus ();

    uart_tx_engine dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [10:0] bits;
        int          rate;
    } frame_t;

    frame_t exp_q[$];
    int     n_cmp = 0;
    int     n_err = 0;

    bit     mon_active = 0;
    frame_t mon_cur;
    int     mon_cyc = 0;
    int     mon_gap = 0;
    int     mon_idx = 0;
    int     last_gap = -1;
    int     busy_run = 0;
    int     last_busy_len = 0;

    function automatic logic [10:0] exp_frame(input logic [7:0] d, input logic eight,
                                              input logic pen, input logic ohel);
        logic [10:0] f;
        logic        p;
        int          n;
        f    = '1;
        f[0] = 1'b0;
        p    = ohel;
        n    = eight ? 8 : 7;
        for (int i = 0; i < n; i++) begin
            f[1 + i] = d[i];
            p        = p ^ d[i];
        end
        if (pen) f[1 + n] = p;
        return f;
    endfunction

    // Line monitor: pops the next expected frame when o_busy rises, checks every clock.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_active = 0;
            mon_gap    = 0;
            busy_run   = 0;
        end else begin
            if (bus.o_busy) busy_run++;
            else begin
                if (busy_run != 0) last_busy_len = busy_run;
                busy_run = 0;
            end
            if (!mon_active && bus.o_busy) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_frame: busy=%b with nothing queued, required busy=0",
                             bus.o_busy);
                end else begin
                    mon_cur    = exp_q.pop_front();
                    mon_active = 1;
                    mon_cyc    = 0;
                    last_gap   = mon_gap;
                    mon_gap    = 0;
                end
            end
            if (mon_active) begin
                mon_idx = mon_cyc / mon_cur.rate;
                n_cmp++;
                if ({bus.o_busy, bus.o_tx} !== {1'b1, mon_cur.bits[mon_idx]}) begin
                    n_err++;
                    $display("FAIL frame_bit%0d: busy,tx=%b%b required 1%b (frame %b cyc %0d)",
                             mon_idx, bus.o_busy, bus.o_tx, mon_cur.bits[mon_idx],
                             mon_cur.bits, mon_cyc);
                end
                mon_cyc++;
                if (mon_cyc == 11 * mon_cur.rate) mon_active = 0;
            end else if (!bus.o_busy) begin
                mon_gap++;
                n_cmp++;
                if (bus.o_tx !== 1'b1) begin
                    n_err++;
                    $display("FAIL idle_line: tx=%b required 1", bus.o_tx);
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit accept);
        frame_t f;
        @(posedge clk);
        #1;
        bus.i_load   = 1'b1;
        bus.i_tx_din = d;
        if (accept) begin
            f.bits = exp_frame(d, bus.i_eight, bus.i_pen, bus.i_ohel);
            f.rate = (bus.i_rate == 0) ? 1 : int'(bus.i_rate);
            exp_q.push_back(f);
        end
        @(posedge clk);
        #1;
        bus.i_load = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit done = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (!mon_active && !bus.o_busy && exp_q.size() == 0 && bus.o_txrdy) begin
                done = 1;
                break;
            end
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL %s_timeout: queued=%0d busy=%b, required idle within %0d clocks",
                     name, exp_q.size(), bus.o_busy, budget);
            exp_q.delete();
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            n_cmp++;
            if ({bus.o_tx, bus.o_txrdy, bus.o_busy} !== 3'b110) begin
                n_err++;
                $display("FAIL reset_hold: tx,txrdy,busy=%b%b%b required 110",
                         bus.o_tx, bus.o_txrdy, bus.o_busy);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #2;
            n_cmp++;
            if ({bus.o_tx, bus.o_txrdy, bus.o_busy} !== 3'b110) begin
                n_err++;
                $display("FAIL reset_release: tx,txrdy,busy=%b%b%b required 110",
                         bus.o_tx, bus.o_txrdy, bus.o_busy);
            end
        end
    endtask

    task automatic test_basic_8n();
        bus.i_rate = 19'd4; bus.i_eight = 1'b1; bus.i_pen = 1'b0; bus.i_ohel = 1'b0;
        send(8'h55, 1);
        #1;
        n_cmp++;
        if ({bus.o_tx, bus.o_txrdy, bus.o_busy} !== 3'b100) begin
            n_err++;
            $display("FAIL load_edge: tx,txrdy,busy=%b%b%b required 100",
                     bus.o_tx, bus.o_txrdy, bus.o_busy);
        end
        @(posedge clk);
        #2;
        n_cmp++;
        if ({bus.o_tx, bus.o_txrdy, bus.o_busy} !== 3'b011) begin
            n_err++;
            $display("FAIL start_edge: tx,txrdy,busy=%b%b%b required 011",
                     bus.o_tx, bus.o_txrdy, bus.o_busy);
        end
        wait_idle(100, "basic");
        n_cmp++;
        if (last_busy_len !== 44) begin
            n_err++;
            $display("FAIL busy_length: %0d clocks, required 44", last_busy_len);
        end
    endtask

    task automatic test_parity();
        bus.i_rate = 19'd4; bus.i_eight = 1'b1; bus.i_pen = 1'b1; bus.i_ohel = 1'b1;
        send(8'hA5, 1);
        wait_idle(100, "parity_odd");
        bus.i_ohel = 1'b0;
        send(8'hA5, 1);
        wait_idle(100, "parity_even");
        send(8'h07, 1);
        wait_idle(100, "parity_even2");
    endtask

    task automatic test_seven_bit();
        bus.i_rate = 19'd4; bus.i_eight = 1'b0; bus.i_pen = 1'b1; bus.i_ohel = 1'b0;
        send(8'hC1, 1);
        wait_idle(100, "seven_par");
        bus.i_pen = 1'b0;
        send(8'hFF, 1);
        wait_idle(100, "seven_nopar");
        bus.i_eight = 1'b1;
    endtask

    task automatic test_rate_edges();
        bus.i_pen = 1'b0;
        bus.i_rate = 19'd0;
        send(8'h96, 1);
        wait_idle(60, "rate0");
        n_cmp++;
        if (last_busy_len !== 11) begin
            n_err++;
            $display("FAIL rate0_length: %0d clocks, required 11", last_busy_len);
        end
        bus.i_rate = 19'd3;
        send(8'h3C, 1);
        // Changing format mid-frame must not affect the frame in flight.
        repeat (5) @(posedge clk);
        #1;
        bus.i_rate = 19'd7; bus.i_pen = 1'b1;
        wait_idle(100, "rate3");
        n_cmp++;
        if (last_busy_len !== 33) begin
            n_err++;
            $display("FAIL rate3_length: %0d clocks, required 33", last_busy_len);
        end
        bus.i_rate = 19'd4; bus.i_pen = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.i_rate = 19'd4; bus.i_eight = 1'b1; bus.i_pen = 1'b0;
        send(8'h11, 1);
        send(8'h22, 1);
        #1;
        n_cmp++;
        if (bus.o_txrdy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_full: txrdy=%b required 0", bus.o_txrdy);
        end
        send(8'h33, 0);
        wait_idle(200, "b2b");
        n_cmp++;
        if (last_gap !== 0) begin
            n_err++;
            $display("FAIL b2b_gap: %0d idle clocks, required 0", last_gap);
        end
    endtask

    task automatic test_load_at_frame_end();
        bus.i_rate = 19'd4;
        send(8'h5A, 1);
        repeat (44) @(posedge clk);
        #1;
        bus.i_load   = 1'b1;
        bus.i_tx_din = 8'hC3;
        begin
            frame_t f;
            f.bits = exp_frame(8'hC3, bus.i_eight, bus.i_pen, bus.i_ohel);
            f.rate = 4;
            exp_q.push_back(f);
        end
        @(posedge clk);
        #1;
        bus.i_load = 1'b0;
        #1;
        n_cmp++;
        if ({bus.o_tx, bus.o_txrdy, bus.o_busy} !== 3'b100) begin
            n_err++;
            $display("FAIL end_load_idle: tx,txrdy,busy=%b%b%b required 100",
                     bus.o_tx, bus.o_txrdy, bus.o_busy);
        end
        wait_idle(100, "end_load");
        n_cmp++;
        if (last_gap !== 1) begin
            n_err++;
            $display("FAIL end_load_gap: %0d idle clocks, required 1", last_gap);
        end
    endtask

    task automatic test_reset_mid_frame();
        bus.i_rate = 19'd4;
        send(8'h0F, 1);
        repeat (21) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.o_tx, bus.o_txrdy, bus.o_busy} !== 3'b110) begin
            n_err++;
            $display("FAIL reset_abort: tx,txrdy,busy=%b%b%b required 110",
                     bus.o_tx, bus.o_txrdy, bus.o_busy);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #2;
            n_cmp++;
            if ({bus.o_tx, bus.o_txrdy, bus.o_busy} !== 3'b110) begin
                n_err++;
                $display("FAIL reset_residual: tx,txrdy,busy=%b%b%b required 110",
                         bus.o_tx, bus.o_txrdy, bus.o_busy);
            end
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL reset_queue: %0d frames pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.i_load   = 1'b0;
        bus.i_tx_din = 8'h00;
        bus.i_eight  = 1'b1;
        bus.i_pen    = 1'b0;
        bus.i_ohel   = 1'b0;
        bus.i_rate   = 19'd4;

        test_reset();
        test_basic_8n();
        test_parity();
        test_seven_bit();
        test_rate_edges();
        test_back_to_back();
        test_load_at_frame_end();
        test_reset_mid_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
